// File: rtl/token_req_queue.sv
// token_req_queue: FIFO of pending items sitting in front of a token-bucket
// shaper. Each buffered item raises one bucket request. When the bucket
// grants, the head item leaves as a single-cycle strobe.
//
// Handshakes:
//   upstream   : an item transfers on a rising edge where in_valid_i & in_ready_o.
//                in_ready_o depends only on registered state.
//   bucket     : a token is consumed on an edge where bkt_req_o & bkt_ready_i.
//                bkt_grant_i arrives one cycle later. A grant that arrives with
//                nothing in flight is recorded in err_o and otherwise ignored.
//   downstream : out_valid_o is a fire-and-forget strobe with no backpressure.
module token_req_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              bkt_req_o,
  input  logic              bkt_ready_i,
  input  logic              bkt_grant_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  // Storage. Contents are not reset because a reset empties the queue logically.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  count_q, count_d;
  logic              inflight_q, inflight_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              err_q, err_d;

  logic              push;
  logic              pop;
  logic              spurious;

  // Output decodes of registered state. There is no path from bkt_ready_i into bkt_req_o.
  always_comb begin
    in_ready_o  = (count_q < FULL_LVL);
    bkt_req_o   = (count_q > {{(LVL_W-1){1'b0}}, inflight_q});
    out_valid_o = out_valid_q;
    out_data_o  = out_data_q;
    level_o     = count_q;
    err_o       = err_q;
  end

  // Event decode. A grant only releases an item when a token was taken the previous cycle.
  always_comb begin
    push     = in_valid_i & in_ready_o;
    pop      = bkt_grant_i & inflight_q;
    spurious = bkt_grant_i & ~inflight_q;
  end

  // Next-state logic for pointers, occupancy, in-flight token, strobe and error flag.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    err_d       = err_q;

    // At most one token is in flight. An unanswered token is dropped and its item is requested again.
    inflight_d  = bkt_req_o & bkt_ready_i;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      out_valid_d = 1'b1;
      out_data_d  = mem[rd_ptr_q];
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase

    if (spurious) begin
      err_d = 1'b1;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      inflight_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  // Write the accepted item into the tail slot.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr_q] <= in_data_i;
    end
  end

endmodule

// File: tb/tb_token_req_queue.sv
// Bench for token_req_queue. The bench plays the part of a bucket that
// grants one cycle after req&ready. It can lose grants and inject stray
// grants on purpose. A reference model keeps the accepted items in a queue,
// together with the occupancy and the in-flight token, and a monitor checks
// every DUT output on the falling edge.
module tb_token_req_queue;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              bkt_ready = 1'b0;
  logic              bkt_grant = 1'b0;
  logic              in_ready_o, bkt_req_o, out_valid_o, err_o;
  logic [DATA_W-1:0] out_data_o;
  logic [LVL_W-1:0]  level_o;

  token_req_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready_o),
    .bkt_req_o(bkt_req_o), .bkt_ready_i(bkt_ready), .bkt_grant_i(bkt_grant),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o),
    .level_o(level_o), .err_o(err_o)
  );

  // scoreboard and reference model state
  logic [DATA_W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int m_count = 0;
  bit m_inflight = 0;
  bit m_err = 0;
  bit m_strobe = 0;
  bit mon_en = 0;

  // stimulus knobs
  int p_valid = 0, p_rdy = 100, p_drop = 0, p_spur = 0;
  bit use_bucket = 0;
  int b_lvl = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // monitor: compare every output with the model and pop released items
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready", in_ready_o, m_count < DEPTH);
      check("bkt_req", bkt_req_o, m_count > int'(m_inflight));
      check("level", level_o, m_count);
      check("err", err_o, m_err);
      check("out_valid", out_valid_o, m_strobe);
      if (out_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_data cyc=%0d actual=%0h expected=<no queued item>", cyc, out_data_o);
        end else begin
          check("out_data", out_data_o, exp_q.pop_front());
        end
      end
    end
  end

  // One clock edge. The model follows the edge using the inputs that were driven before it.
  task automatic tick();
    bit push, pop, spur, req;
    @(posedge clk);
    push = in_valid && (m_count < DEPTH);
    pop  = bkt_grant && m_inflight;
    spur = bkt_grant && !m_inflight;
    req  = m_count > int'(m_inflight);
    if (use_bucket) begin
      if (req && bkt_ready) b_lvl -= 16;
      b_lvl += 3;
      if (b_lvl > 32) b_lvl = 32;
    end
    if (!rst_n) begin
      m_count = 0; m_inflight = 0; m_err = 0; m_strobe = 0;
      exp_q.delete();
    end else begin
      if (push) exp_q.push_back(in_data);
      m_count    = m_count + int'(push) - int'(pop);
      m_err      = m_err | spur;
      m_strobe   = pop;
      m_inflight = req && bkt_ready;
    end
    #1;
    cyc++;
  endtask

  // driver: choose the inputs for the next edge
  task automatic drive_next();
    in_valid  = ($urandom_range(0, 99) < p_valid);
    in_data   = DATA_W'($urandom);
    bkt_ready = use_bucket ? (b_lvl >= 16) : ($urandom_range(0, 99) < p_rdy);
    if (m_inflight) bkt_grant = !($urandom_range(0, 99) < p_drop);
    else            bkt_grant = ($urandom_range(0, 99) < p_spur);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive_next();
      tick();
    end
  endtask

  task automatic set_mode(input int v, input int r, input int d, input int s);
    p_valid = v; p_rdy = r; p_drop = d; p_spur = s;
  endtask

  initial begin
    int k, lat;
    int nxt;
    bit pushed;

    // reset
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    mon_en = 1'b1;

    // single item A5 with tokens available: two edges from the accepting edge to the strobe
    in_valid = 1'b1; in_data = 8'hA5; bkt_ready = 1'b1; bkt_grant = 1'b0;
    tick();
    set_mode(0, 100, 0, 0);
    lat = -1;
    for (k = 1; k <= 6; k++) begin
      drive_next();
      tick();
      if (lat < 0 && out_valid_o === 1'b1) lat = k;
    end
    check("latency_edges", lat, 2);
    check("single_level", level_o, 0);

    // fill with 01..04 while the bucket is empty, then offer 05
    set_mode(100, 0, 0, 0);
    nxt = 1;
    for (k = 0; k < 18; k++) begin
      if (k == 6) p_rdy = 100;
      drive_next();
      in_valid = (nxt <= 5);
      in_data  = DATA_W'(nxt);
      pushed   = in_valid && (m_count < DEPTH);
      tick();
      if (pushed) nxt++;
    end
    check("fill_all_accepted", nxt, 6);

    // token bucket: DEN=16, RATE_NUM=3, BURST_MAX=2, 8 items
    use_bucket = 1'b1; b_lvl = 32;
    set_mode(100, 0, 0, 0);
    run(8);
    p_valid = 0;
    run(50);
    use_bucket = 1'b0;

    // bucket not ready for 10 cycles with items queued, then resume
    set_mode(100, 100, 0, 0);
    run(3);
    set_mode(0, 0, 0, 0);
    run(10);
    p_rdy = 100;
    run(10);

    // stray grant with nothing in flight
    set_mode(0, 0, 0, 0);
    run(2);
    bkt_ready = 1'b0; bkt_grant = 1'b1; in_valid = 1'b0;
    tick();
    run(3);

    // random traffic with lost grants
    for (int ph = 0; ph < 6; ph++) begin
      set_mode($urandom_range(20, 100), $urandom_range(10, 100), $urandom_range(0, 30), 0);
      run(150);
    end

    // reset with queued items and a grant pending, then a stray grant
    set_mode(100, 0, 0, 0);
    run(3);
    bkt_ready = 1'b1; in_valid = 1'b0; bkt_grant = 1'b0;
    tick();
    bkt_ready = 1'b0; bkt_grant = m_inflight;
    tick();
    rst_n = 1'b0; bkt_grant = 1'b1;
    tick();
    rst_n = 1'b1;
    set_mode(0, 0, 0, 0);
    run(2);
    bkt_grant = 1'b1; bkt_ready = 1'b0;
    tick();
    run(2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // random traffic including occasional stray grants
    for (int ph = 0; ph < 4; ph++) begin
      set_mode($urandom_range(30, 90), $urandom_range(30, 100), $urandom_range(0, 20), 2);
      run(150);
    end

    // drain
    set_mode(0, 100, 0, 0);
    run(30);
    check("drain_empty", exp_q.size(), 0);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // safety net on total run time
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "timeout");
  end
endmodule
